// File: rtl/word_typing_checker.sv
// word_typing_checker: consumer end of the word-delivery interface. Latches a
//   4-letter word, matches keystrokes letter by letter, counts mistakes and
//   finished words, and pulses word_complete to request the next word.
// Latency: every output is registered, so a key accepted on an edge shows its
//   effect right after that edge. The next word is latched 3 edges after the
//   edge that accepts the final letter.
// Backpressure: none. A key_valid seen outside the typing window is dropped.
// Ports:
//   clk, reset        single clock; synchronous active-high reset
//   current_word      word from the delivery block; letter 0 in the MSBs
//   key_valid/key_code one-cycle keystroke strobe and letter code (26-31 = non-letter)
//   word_complete     one-cycle pulse that advances the delivery pipeline
//   active            high while keystrokes are being matched
//   char_pos          index of the next letter expected
//   mistake           one-cycle pulse after a wrong letter
//   error_count       saturating wrong-letter count
//   words_done        saturating finished-word count
module word_typing_checker #(
  parameter int WORD_LEN = 4,
  parameter int CHAR_W   = 5,
  parameter int ERR_W    = 8,
  parameter int SCORE_W  = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WORD_LEN*CHAR_W-1:0] current_word,
  input  logic                       key_valid,
  input  logic [CHAR_W-1:0]          key_code,
  output logic                       word_complete,
  output logic                       active,
  output logic [2:0]                 char_pos,
  output logic                       mistake,
  output logic [ERR_W-1:0]           error_count,
  output logic [SCORE_W-1:0]         words_done
);

  typedef enum logic [2:0] {
    PRIME1,
    GAP1,
    PRIME2,
    GAP2,
    LOAD,
    TYPE,
    DONE
  } state_t;

  localparam logic [CHAR_W-1:0] LAST_LETTER = CHAR_W'(25);
  localparam logic [2:0]        LAST_POS    = 3'(WORD_LEN - 1);

  state_t                       state;
  logic [WORD_LEN*CHAR_W-1:0]   word_reg;
  logic [CHAR_W-1:0]            exp_letter;
  logic                         is_letter;
  logic                         key_match;

  // Letter 0 sits in the most significant slice, so position i maps to
  // slice WORD_LEN-1-i counting from the LSB end.
  always_comb begin
    exp_letter = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (char_pos == 3'(i)) begin
        exp_letter = word_reg[(WORD_LEN-1-i)*CHAR_W +: CHAR_W];
      end
    end
  end

  assign is_letter = (key_code <= LAST_LETTER);
  assign key_match = (key_code == exp_letter);

  // Outputs are set on the edge that leaves the state that owns them, which
  // keeps them registered while still giving the all-zero reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PRIME1;
      word_reg      <= '0;
      word_complete <= 1'b0;
      active        <= 1'b0;
      char_pos      <= 3'd0;
      mistake       <= 1'b0;
      error_count   <= '0;
      words_done    <= '0;
    end else begin
      word_complete <= 1'b0;
      mistake       <= 1'b0;
      case (state)
        PRIME1: begin
          word_complete <= 1'b1;
          state         <= GAP1;
        end
        GAP1: begin
          state <= PRIME2;
        end
        PRIME2: begin
          word_complete <= 1'b1;
          state         <= GAP2;
        end
        GAP2: begin
          state <= LOAD;
        end
        LOAD: begin
          word_reg <= current_word;
          char_pos <= 3'd0;
          active   <= 1'b1;
          state    <= TYPE;
        end
        TYPE: begin
          if (key_valid && is_letter) begin
            if (key_match) begin
              if (char_pos == LAST_POS) begin
                // The completion pulse goes out now so delivery gets the
                // request one cycle after the final key.
                word_complete <= 1'b1;
                active        <= 1'b0;
                char_pos      <= 3'd0;
                if (words_done != '1) begin
                  words_done <= words_done + 1'b1;
                end
                state <= DONE;
              end else begin
                char_pos <= char_pos + 3'd1;
              end
            end else begin
              mistake <= 1'b1;
              if (error_count != '1) begin
                error_count <= error_count + 1'b1;
              end
            end
          end
        end
        DONE: begin
          state <= GAP2;
        end
        default: begin
          state <= PRIME1;
        end
      endcase
    end
  end

endmodule
